// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 keypad scanner: FSM encodings, matrix size
// and the row-priority helper used when encoding a frame's first hit.
package keypad_scanner_pkg;

   localparam int COLS = 4;
   localparam int ROWS = 4;

   localparam logic [3:0] NO_ROW = 4'b1111;

   localparam logic [1:0] KP_IDLE    = 2'd0;
   localparam logic [1:0] KP_CONFIRM = 2'd1;
   localparam logic [1:0] KP_HELD    = 2'd2;

   // Index of the lowest-numbered low (closed) row bit; only meaningful when
   // at least one bit is low.
   function automatic logic [1:0] first_low_row(input logic [3:0] r);
      logic [1:0] idx;
      idx = 2'd3;
      if (!r[2]) idx = 2'd2;
      if (!r[1]) idx = 2'd1;
      if (!r[0]) idx = 2'd0;
      return idx;
   endfunction

endpackage

// File: rtl/kp_scan_tick.sv
// Column dwell divider and column rotation: one tick per SCAN_DIV cycles,
// frame_end on the tick that finishes the last column.
module kp_scan_tick
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic       clk_crystal,
   input  logic       rst,
   output logic       tick,
   output logic       frame_end,
   output logic [1:0] col_idx,
   output logic [3:0] col
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

   logic [DW-1:0] div_cnt;

   always_ff @(posedge clk_crystal) begin
      if (!rst) begin
         div_cnt <= '0;
         col_idx <= '0;
      end else if (tick) begin
         div_cnt <= '0;
         col_idx <= col_idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   always_comb begin
      tick      = (div_cnt == DIV_LAST);
      frame_end = tick && (col_idx == 2'(COLS - 1));
      col       = ~(4'b0001 << col_idx);
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: per-frame hit/code capture plus a frame-level
// debounce FSM that reports one accepted key with a single-cycle strobe.
//
// state      | meaning
// -----------+------------------------------------------------------------
// KP_IDLE    | no key accepted; waiting for a frame with any hit
// KP_CONFIRM | candidate latched; counting consecutive matching frames
// KP_HELD    | key accepted; counting consecutive non-matching frames
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk_crystal,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_down
);

   localparam logic [3:0] DEB_CNT = 4'(DEBOUNCE);

   logic       tick;
   logic       frame_end;
   logic [1:0] col_idx;

   kp_scan_tick #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clk_crystal (clk_crystal),
      .rst         (rst),
      .tick        (tick),
      .frame_end   (frame_end),
      .col_idx     (col_idx),
      .col         (col)
   );

   logic [3:0] row_meta;
   logic [3:0] row_sync;

   always_ff @(posedge clk_crystal) begin
      if (!rst) begin
         row_meta <= NO_ROW;
         row_sync <= NO_ROW;
      end else begin
         row_meta <= row;
         row_sync <= row_meta;
      end
   end

   logic       cur_hit;
   logic [3:0] cur_code;
   logic       acc_hit;
   logic [3:0] acc_code;
   logic       frame_hit;
   logic [3:0] frame_code;

   // Earlier columns already own the frame code, so only the first hit sticks.
   always_comb begin
      cur_hit    = (row_sync != NO_ROW);
      cur_code   = {first_low_row(row_sync), col_idx};
      frame_hit  = acc_hit | cur_hit;
      frame_code = acc_hit ? acc_code : cur_code;
   end

   always_ff @(posedge clk_crystal) begin
      if (!rst) begin
         acc_hit  <= 1'b0;
         acc_code <= '0;
      end else if (tick) begin
         if (frame_end) begin
            acc_hit  <= 1'b0;
            acc_code <= '0;
         end else if (!acc_hit && cur_hit) begin
            acc_hit  <= 1'b1;
            acc_code <= cur_code;
         end
      end
   end

   logic [1:0] state;
   logic [3:0] cand;
   logic [3:0] cnt;
   logic [3:0] cnt_inc;
   logic       match;

   always_comb begin
      cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
      match   = frame_hit && (frame_code == cand);
   end

   always_ff @(posedge clk_crystal) begin
      if (!rst) begin
         state     <= KP_IDLE;
         cand      <= '0;
         cnt       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_down  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         if (frame_end) begin
            case (state)
               KP_IDLE: begin
                  if (frame_hit) begin
                     cand <= frame_code;
                     if (DEBOUNCE == 1) begin
                        state     <= KP_HELD;
                        key_code  <= frame_code;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        cnt       <= '0;
                     end else begin
                        state <= KP_CONFIRM;
                        cnt   <= 4'd1;
                     end
                  end
               end
               KP_CONFIRM: begin
                  if (match) begin
                     if (cnt_inc >= DEB_CNT) begin
                        state     <= KP_HELD;
                        key_code  <= cand;
                        key_valid <= 1'b1;
                        key_down  <= 1'b1;
                        cnt       <= '0;
                     end else begin
                        cnt <= cnt_inc;
                     end
                  end else begin
                     state <= KP_IDLE;
                     cnt   <= '0;
                  end
               end
               KP_HELD: begin
                  if (match) begin
                     cnt <= '0;
                  end else if (cnt_inc >= DEB_CNT) begin
                     state    <= KP_IDLE;
                     key_down <= 1'b0;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
               default: begin
                  state <= KP_IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: directed scenarios plus random key
// sequences, compared cycle by cycle against a frame-level reference model.
module tb_keypad_scanner;

   localparam int SD    = 4;
   localparam int DB    = 3;
   localparam int FRAME = 4 * SD;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_down;
   logic [15:0] keys;

   int tests  = 0;
   int fails  = 0;
   int pulses = 0;
   int phase  = 0;

   // reference model: 0 idle, 1 confirming, 2 held
   int         m_state;
   int         m_cnt;
   logic [3:0] m_cand;
   logic [3:0] m_code;
   logic       m_down;
   logic       m_valid;

   always #5 clk = ~clk;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk_crystal (clk),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_down    (key_down)
   );

   // key (r,c) pulls row r low only while column c is driven low
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         if (!col[c])
            for (int r = 0; r < 4; r++)
               if (keys[r*4 + c]) row[r] = 1'b0;
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at phase %0d", tag, obs, exp, phase);
      end
   endtask

   task automatic frame_of(input logic [15:0] k, output logic h, output logic [3:0] code);
      h    = 1'b0;
      code = 4'd0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (!h && k[r*4 + c]) begin
               h    = 1'b1;
               code = 4'(r*4 + c);
            end
   endtask

   task automatic model_accept();
      m_state = 2;
      m_code  = m_cand;
      m_valid = 1'b1;
      m_down  = 1'b1;
      m_cnt   = 0;
   endtask

   task automatic model_frame(input logic h, input logic [3:0] fc);
      case (m_state)
         0: if (h) begin
               m_cand = fc;
               m_cnt  = 1;
               if (DB == 1) model_accept(); else m_state = 1;
            end
         1: if (h && fc == m_cand) begin
               m_cnt++;
               if (m_cnt >= DB) model_accept();
            end else begin
               m_state = 0;
               m_cnt   = 0;
            end
         default: begin
            if (h && fc == m_cand) m_cnt = 0; else m_cnt++;
            if (m_cnt >= DB) begin
               m_state = 0;
               m_down  = 1'b0;
               m_cnt   = 0;
            end
         end
      endcase
   endtask

   task automatic cycle_check(input logic h, input logic [3:0] fc);
      logic [3:0] one;
      logic [3:0] exp_col;
      one = 4'b0001;
      @(posedge clk);
      phase++;
      m_valid = 1'b0;
      if (phase % FRAME == 0) model_frame(h, fc);
      @(negedge clk);
      exp_col = ~(one << ((phase / SD) % 4));
      if (key_valid) pulses++;
      check("col", col, exp_col);
      check("key_valid", {3'b0, key_valid}, {3'b0, m_valid});
      check("key_down", {3'b0, key_down}, {3'b0, m_down});
      check("key_code", key_code, m_code);
   endtask

   task automatic run_frames(input logic [15:0] mask, input int n);
      logic       h;
      logic [3:0] fc;
      keys = mask;
      frame_of(mask, h, fc);
      repeat (n * FRAME) cycle_check(h, fc);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_col", col, 4'b1110);
      check("rst_valid", {3'b0, key_valid}, 4'd0);
      check("rst_down", {3'b0, key_down}, 4'd0);
      check("rst_code", key_code, 4'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst     = 1'b1;
      m_state = 0;
      m_cnt   = 0;
      m_cand  = 4'd0;
      m_code  = 4'd0;
      m_down  = 1'b0;
      m_valid = 1'b0;
      phase   = 0;
   endtask

   function automatic logic [15:0] key_bit(input int r, input int c);
      logic [15:0] m;
      m = 16'd0;
      m[r*4 + c] = 1'b1;
      return m;
   endfunction

   initial begin
      int p0;
      logic [15:0] mask;
      rst  = 1'b0;
      keys = 16'd0;
      @(negedge clk);
      do_reset();

      // idle rotation
      run_frames(16'd0, 2);

      // clean press row1/col2
      p0 = pulses;
      run_frames(key_bit(1, 2), 6);
      check("clean_code", key_code, 4'b0110);
      run_frames(16'd0, 4);
      check("clean_pulses", 4'(pulses - p0), 4'd1);

      // bounce: present, absent, present x3
      p0 = pulses;
      run_frames(key_bit(0, 0), 1);
      run_frames(16'd0, 1);
      run_frames(key_bit(0, 0), 3);
      check("bounce_pulses", 4'(pulses - p0), 4'd1);
      run_frames(16'd0, 4);

      // two keys: lower column wins, then rollover needs release+confirm
      p0 = pulses;
      run_frames(key_bit(3, 0) | key_bit(0, 1), 5);
      check("dual_code", key_code, 4'b1100);
      run_frames(key_bit(0, 1), 8);
      check("rollover_code", key_code, 4'b0001);
      run_frames(16'd0, 4);
      check("dual_pulses", 4'(pulses - p0), 4'd2);

      // reset in the middle of a confirm
      p0 = pulses;
      run_frames(key_bit(2, 1), 2);
      do_reset();
      check("midrst_pulses", 4'(pulses - p0), 4'd0);
      run_frames(key_bit(2, 1), 4);
      check("midrst_code", key_code, 4'b1001);
      run_frames(16'd0, 4);

      // short release while held keeps key_down
      p0 = pulses;
      run_frames(key_bit(2, 3), 3);
      run_frames(16'd0, 1);
      run_frames(key_bit(2, 3), 3);
      check("glitch_down", {3'b0, key_down}, 4'd1);
      run_frames(16'd0, 4);
      check("glitch_pulses", 4'(pulses - p0), 4'd1);

      // random key sequences
      for (int s = 0; s < 14; s++) begin
         int kind;
         kind = int'($urandom_range(0, 3));
         mask = 16'd0;
         if (kind != 0)
            mask = key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if (kind == 3)
            mask = mask | key_bit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         run_frames(mask, int'($urandom_range(1, 5)));
      end
      run_frames(16'd0, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
